// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: step constants, Rcon ROM and GF(2^8) helpers
// used by both the encrypt and decrypt iterative cores.
package aes128_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    localparam logic [5:0] ST_IDLE        = 6'd0;
    localparam logic [5:0] ST_KEYEXP_LAST = 6'd10;
    localparam logic [5:0] ST_ADDKEY      = 6'd11;
    localparam logic [5:0] ST_ROUND_FIRST = 6'd12;
    localparam logic [5:0] ST_FINAL       = 6'd21;

    function automatic byte_t rcon(input logic [5:0] idx);
        byte_t r;
        case (idx)
            6'd1:    r = 8'h01;
            6'd2:    r = 8'h02;
            6'd3:    r = 8'h04;
            6'd4:    r = 8'h08;
            6'd5:    r = 8'h10;
            6'd6:    r = 8'h20;
            6'd7:    r = 8'h40;
            6'd8:    r = 8'h80;
            6'd9:    r = 8'h1b;
            6'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t acc;
        byte_t sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? sh : 8'h00);
            sh  = xtime(sh);
        end
        return acc;
    endfunction

    function automatic byte_t rotl8(input byte_t x, input logic [2:0] n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Multiplicative inverse as a^254 through a fixed square-and-multiply chain; 0 maps to 0.
    function automatic byte_t gf_inv(input byte_t a);
        byte_t x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gmul(a, a);
        x3   = gmul(x2, a);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        return gmul(x252, x2);
    endfunction

    function automatic byte_t sbox(input byte_t a);
        byte_t b;
        b = gf_inv(a);
        return b ^ rotl8(b, 3'd1) ^ rotl8(b, 3'd2) ^ rotl8(b, 3'd3) ^ rotl8(b, 3'd4) ^ 8'h63;
    endfunction

    function automatic byte_t inv_sbox(input byte_t s);
        return gf_inv(rotl8(s, 3'd1) ^ rotl8(s, 3'd3) ^ rotl8(s, 3'd6) ^ 8'h05);
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic word_t inv_mix_column(input word_t col);
        byte_t a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes128_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes128_inv_round
    import aes128_pkg::*;
(
    input  logic [127:0] data,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] next
);

    byte_t ark_s [16];

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            // Row r is rotated right by r, so output column c reads input column c-r.
            localparam int SRC = 4 * ((c + 4 - r) % 4) + r;
            assign ark_s[4*c+r] = inv_sbox(data[127-8*SRC -: 8]) ^ rk[127-8*(4*c+r) -: 8];
        end

        word_t col_s;
        assign col_s = {ark_s[4*c], ark_s[4*c+1], ark_s[4*c+2], ark_s[4*c+3]};
        assign next[127-32*c -: 32] = last ? col_s : inv_mix_column(col_s);
    end

endmodule

// File: rtl/aes128_inv_iter.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10, then one
// inverse round per clock while stepping the key schedule backwards.
module aes128_inv_iter
    import aes128_pkg::*;
#(
    parameter int NR = 10
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic [127:0] out,
    output logic         busy,
    output logic         done,
    output logic [5:0]   state
);

    // Backward steps at states 12..21 use Rcon[22 - state].
    localparam logic [5:0] BACK_BASE = 6'(2 * NR + 2);

    logic [127:0] data_r;
    logic [127:0] key_r;
    logic [127:0] key_next_s;
    logic [127:0] round_out_s;
    logic         backward_s;
    logic         last_s;
    logic [5:0]   rcon_pos_s;
    word_t        sb_in_s;
    word_t        t_s;

    // One key-schedule step, forward or backward, sharing the same four S-boxes
    always_comb begin
        backward_s = (state > ST_ADDKEY);
        if (backward_s) begin
            rcon_pos_s = BACK_BASE - state;
            sb_in_s    = key_r[31:0] ^ key_r[63:32];
        end else begin
            rcon_pos_s = state;
            sb_in_s    = key_r[31:0];
        end
        t_s = sub_word({sb_in_s[23:0], sb_in_s[31:24]}) ^ {rcon(rcon_pos_s), 24'h000000};
        if (backward_s) begin
            key_next_s[127:96] = key_r[127:96] ^ t_s;
            key_next_s[95:64]  = key_r[95:64] ^ key_r[127:96];
            key_next_s[63:32]  = key_r[63:32] ^ key_r[95:64];
            key_next_s[31:0]   = key_r[31:0] ^ key_r[63:32];
        end else begin
            key_next_s[127:96] = key_r[127:96] ^ t_s;
            key_next_s[95:64]  = key_r[95:64] ^ key_r[127:96] ^ t_s;
            key_next_s[63:32]  = key_r[63:32] ^ key_r[95:64] ^ key_r[127:96] ^ t_s;
            key_next_s[31:0]   = key_r[31:0] ^ key_r[63:32] ^ key_r[95:64] ^ key_r[127:96] ^ t_s;
        end
    end

    assign last_s = (state == ST_FINAL);

    aes128_inv_round u_round (
        .data (data_r),
        .rk   (key_next_s),
        .last (last_s),
        .next (round_out_s)
    );

    // Step sequencer with the data, key and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_r <= 128'h0;
            key_r  <= 128'h0;
            out    <= 128'h0;
            busy   <= 1'b0;
            done   <= 1'b0;
            state  <= ST_IDLE;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    data_r <= in;
                    key_r  <= key;
                    busy   <= 1'b1;
                    state  <= 6'd1;
                end
            end else if (state <= ST_KEYEXP_LAST) begin
                key_r <= key_next_s;
                state <= state + 6'd1;
            end else if (state == ST_ADDKEY) begin
                data_r <= data_r ^ key_r;
                state  <= ST_ROUND_FIRST;
            end else if (state < ST_FINAL) begin
                data_r <= round_out_s;
                key_r  <= key_next_s;
                state  <= state + 6'd1;
            end else begin
                // Final step; any unreachable step value also falls back to idle here.
                if (state == ST_FINAL) begin
                    out   <= round_out_s;
                    key_r <= key_next_s;
                    done  <= 1'b1;
                end
                busy  <= 1'b0;
                state <= ST_IDLE;
            end
        end
    end

endmodule
